// File: rtl/residu.sv
// LPC analysis filter A(z): y[n] = round((sum a[j]*x[n-j]) << 3) over one subframe.
// Every memory access and every add/multiply is routed through the shared port and units.
module residu #(
    parameter int L = 40,
    parameter int M = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] xAddr,
    input  logic [11:0] aAddr,
    input  logic [11:0] yAddr,
    input  logic [31:0] memIn,
    output logic [11:0] memReadAddr,
    output logic [11:0] memWriteAddr,
    output logic        memWriteEn,
    output logic [31:0] memOut,
    output logic [15:0] addOutA,
    output logic [15:0] addOutB,
    input  logic [15:0] addIn,
    output logic [15:0] subOutA,
    output logic [15:0] subOutB,
    input  logic [15:0] subIn,
    output logic [31:0] L_addOutA,
    output logic [31:0] L_addOutB,
    input  logic [31:0] L_addIn,
    output logic [15:0] L_multOutA,
    output logic [15:0] L_multOutB,
    input  logic [31:0] L_multIn,
    output logic [15:0] L_macOutA,
    output logic [15:0] L_macOutB,
    output logic [31:0] L_macOutC,
    input  logic [31:0] L_macIn,
    output logic [31:0] L_shlOutVar1,
    output logic [15:0] L_shlNumShiftOut,
    output logic        L_shlReady,
    input  logic [31:0] L_shlIn,
    input  logic        L_shlDone,
    output logic        done
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_LOOP = 4'd1;
    localparam logic [3:0] S_RDX  = 4'd2;
    localparam logic [3:0] S_MULT = 4'd3;
    localparam logic [3:0] S_JCHK = 4'd4;
    localparam logic [3:0] S_RDA  = 4'd5;
    localparam logic [3:0] S_MAC  = 4'd6;
    localparam logic [3:0] S_SHL1 = 4'd7;
    localparam logic [3:0] S_SHL2 = 4'd8;
    localparam logic [3:0] S_WR   = 4'd9;
    localparam logic [3:0] S_INC  = 4'd10;

    localparam logic [5:0] I_END = 6'(L);
    localparam logic [5:0] J_END = 6'(M);

    logic [3:0]         state;
    logic [5:0]         i;
    logic [5:0]         j;
    logic signed [15:0] temp_x;
    logic signed [15:0] temp_a;
    logic signed [31:0] temp_s;

    // Only the low 12 address bits and the low 16 data bits are meaningful here.
    logic unused_bits;
    assign unused_bits = ^{addIn[15:12], subIn[15:12], memIn[31:16]};

    always_comb begin
        memReadAddr      = '0;
        memWriteAddr     = '0;
        memWriteEn       = 1'b0;
        memOut           = '0;
        addOutA          = '0;
        addOutB          = '0;
        subOutA          = '0;
        subOutB          = '0;
        L_addOutA        = '0;
        L_addOutB        = '0;
        L_multOutA       = '0;
        L_multOutB       = '0;
        L_macOutA        = '0;
        L_macOutB        = '0;
        L_macOutC        = '0;
        L_shlOutVar1     = '0;
        L_shlNumShiftOut = '0;
        L_shlReady       = 1'b0;
        done             = 1'b0;
        case (state)
            S_IDLE: ;
            S_LOOP: begin
                if (i >= I_END) begin
                    done = 1'b1;
                end else begin
                    addOutA     = {4'b0, xAddr};
                    addOutB     = {10'b0, i};
                    memReadAddr = addIn[11:0];
                end
            end
            S_RDX:  memReadAddr = aAddr;
            S_MULT: begin
                L_multOutA = temp_x;
                L_multOutB = memIn[15:0];
            end
            S_JCHK: begin
                if (j <= J_END) begin
                    addOutA     = {4'b0, aAddr};
                    addOutB     = {10'b0, j};
                    memReadAddr = addIn[11:0];
                end
            end
            // x[i-j] wraps modulo 4096, so i<j lands in the history below xAddr.
            S_RDA: begin
                addOutA     = {4'b0, xAddr};
                addOutB     = {10'b0, i};
                subOutA     = addIn;
                subOutB     = {10'b0, j};
                memReadAddr = subIn[11:0];
            end
            S_MAC: begin
                L_macOutA = temp_a;
                L_macOutB = memIn[15:0];
                L_macOutC = temp_s;
                addOutA   = {10'b0, j};
                addOutB   = 16'd1;
            end
            S_SHL1: begin
                L_shlOutVar1     = temp_s;
                L_shlNumShiftOut = 16'd3;
                L_shlReady       = 1'b1;
            end
            S_SHL2: ;
            S_WR: begin
                L_addOutA    = temp_s;
                L_addOutB    = 32'h0000_8000;
                addOutA      = {4'b0, yAddr};
                addOutB      = {10'b0, i};
                memWriteAddr = addIn[11:0];
                memWriteEn   = 1'b1;
                memOut       = {{16{L_addIn[31]}}, L_addIn[31:16]};
            end
            S_INC: begin
                addOutA = {10'b0, i};
                addOutB = 16'd1;
            end
            default: done = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            i      <= '0;
            j      <= '0;
            temp_x <= '0;
            temp_a <= '0;
            temp_s <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    i <= '0;
                    j <= '0;
                    if (start) state <= S_LOOP;
                end
                S_LOOP: state <= (i >= I_END) ? S_IDLE : S_RDX;
                S_RDX: begin
                    temp_x <= memIn[15:0];
                    state  <= S_MULT;
                end
                S_MULT: begin
                    temp_s <= L_multIn;
                    j      <= 6'd1;
                    state  <= S_JCHK;
                end
                S_JCHK: state <= (j > J_END) ? S_SHL1 : S_RDA;
                S_RDA: begin
                    temp_a <= memIn[15:0];
                    state  <= S_MAC;
                end
                S_MAC: begin
                    temp_s <= L_macIn;
                    j      <= addIn[5:0];
                    state  <= S_JCHK;
                end
                S_SHL1: state <= S_SHL2;
                S_SHL2: begin
                    if (L_shlDone) begin
                        temp_s <= L_shlIn;
                        state  <= S_WR;
                    end
                end
                S_WR: state <= S_INC;
                S_INC: begin
                    i     <= addIn[5:0];
                    state <= S_LOOP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_residu.sv
// Bench for residu: scratch memory, shared arithmetic units and shifter handshake are
// modelled here; outputs are compared with a direct G.729 residual computation.
module tb_residu;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [11:0] xAddr, aAddr, yAddr;
    logic [31:0] memIn;
    logic [11:0] memReadAddr, memWriteAddr;
    logic        memWriteEn;
    logic [31:0] memOut;
    logic [15:0] addOutA, addOutB, addIn, subOutA, subOutB, subIn;
    logic [31:0] L_addOutA, L_addOutB, L_addIn;
    logic [15:0] L_multOutA, L_multOutB;
    logic [31:0] L_multIn;
    logic [15:0] L_macOutA, L_macOutB;
    logic [31:0] L_macOutC, L_macIn;
    logic [31:0] L_shlOutVar1, L_shlIn;
    logic [15:0] L_shlNumShiftOut;
    logic        L_shlReady, L_shlDone, done;

    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    int ncmp = 0;
    int nfail = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    int shl_delay = 0;
    int shl_cnt = 0;
    bit shl_pend = 1'b0;
    logic [31:0] shl_var = '0;
    logic [15:0] shl_n = '0;

    logic [31:0] mem [4096];
    logic signed [15:0] av [11];
    logic signed [15:0] xv [50];   // xv[k] holds x[k-10]

    always #5 clk = ~clk;

    residu dut (
        .clk(clk), .reset(reset), .start(start),
        .xAddr(xAddr), .aAddr(aAddr), .yAddr(yAddr),
        .memIn(memIn), .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
        .memWriteEn(memWriteEn), .memOut(memOut),
        .addOutA(addOutA), .addOutB(addOutB), .addIn(addIn),
        .subOutA(subOutA), .subOutB(subOutB), .subIn(subIn),
        .L_addOutA(L_addOutA), .L_addOutB(L_addOutB), .L_addIn(L_addIn),
        .L_multOutA(L_multOutA), .L_multOutB(L_multOutB), .L_multIn(L_multIn),
        .L_macOutA(L_macOutA), .L_macOutB(L_macOutB), .L_macOutC(L_macOutC), .L_macIn(L_macIn),
        .L_shlOutVar1(L_shlOutVar1), .L_shlNumShiftOut(L_shlNumShiftOut),
        .L_shlReady(L_shlReady), .L_shlIn(L_shlIn), .L_shlDone(L_shlDone),
        .done(done)
    );

    function automatic logic [31:0] clamp(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        return clamp(longint'($signed(a)) + longint'($signed(b)));
    endfunction

    function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
        return clamp(longint'($signed(a)) * longint'($signed(b)) * 2);
    endfunction

    function automatic logic [31:0] sat_shl(input logic [31:0] v, input logic [15:0] n);
        int s;
        s = (n > 16'd31) ? 31 : int'(n);
        return clamp(longint'($signed(v)) <<< s);
    endfunction

    always_comb begin
        addIn    = addOutA + addOutB;
        subIn    = subOutA - subOutB;
        L_addIn  = sat_add(L_addOutA, L_addOutB);
        L_multIn = l_mult(L_multOutA, L_multOutB);
        L_macIn  = sat_add(L_macOutC, l_mult(L_macOutA, L_macOutB));
    end

    // Reference: straight G.729 Residu arithmetic on the stored arrays.
    function automatic logic [31:0] ref_y(input int n);
        logic [31:0] acc;
        acc = l_mult(av[0], xv[n + 10]);
        for (int k = 1; k <= 10; k++) acc = sat_add(acc, l_mult(av[k], xv[n + 10 - k]));
        acc = sat_shl(acc, 16'd3);
        acc = sat_add(acc, 32'h0000_8000);
        return {{16{acc[31]}}, acc[31:16]};
    endfunction

    function automatic logic [31:0] yw(input int n);
        return mem[12'(yAddr + 12'(n))];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: capture writes/reads/shift requests mid-cycle, drive responses after the edge.
    task automatic tick();
        logic [11:0] ra;
        logic [11:0] ofs;
        @(negedge clk);
        ra = memReadAddr;
        if (memWriteEn) begin
            ofs = memWriteAddr - yAddr;
            if (ofs >= 12'd40) bad_wr++;
            mem[memWriteAddr] = memOut;
            wr_cnt++;
        end
        if (L_shlReady) begin
            shl_var = L_shlOutVar1;
            shl_n = L_shlNumShiftOut;
            shl_pend = 1'b1;
            shl_cnt = 0;
        end else if (shl_pend) begin
            if (L_shlDone) shl_pend = 1'b0;
            else shl_cnt++;
        end
        @(posedge clk);
        #1;
        memIn = mem[ra];
        L_shlDone = shl_pend && (shl_cnt >= shl_delay);
        L_shlIn = sat_shl(shl_var, shl_n);
    endtask

    task automatic load(input logic [11:0] xa, input logic [11:0] aa, input logic [11:0] ya);
        xAddr = xa;
        aAddr = aa;
        yAddr = ya;
        for (int k = 0; k < 50; k++) mem[12'(xa - 12'd10 + 12'(k))] = {{16{xv[k][15]}}, xv[k]};
        for (int k = 0; k < 11; k++) mem[12'(aa + 12'(k))] = {{16{av[k][15]}}, av[k]};
        for (int k = 0; k < 40; k++) mem[12'(ya + 12'(k))] = SENT;
    endtask

    task automatic check_y(input string tag);
        for (int n = 0; n < 40; n++) check($sformatf("%s y[%0d]", tag, n), yw(n), ref_y(n));
    endtask

    task automatic run_sub(input string tag, input int exp_cyc, input bit poke);
        int cyc, got, pulses;
        bit seen;
        got = 0;
        pulses = 0;
        seen = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 4000) begin
            if (done) begin
                pulses++;
                if (!seen) begin
                    seen = 1'b1;
                    got = cyc;
                    if (poke) start = 1'b1;
                end
            end
            if (seen && cyc >= got + 5) break;
            tick();
            cyc++;
            if (seen && cyc == got + 1) start = 1'b0;
        end
        check({tag, " finished"}, 32'(seen), 32'd1);
        check({tag, " done cycle"}, got, exp_cyc);
        check({tag, " done pulses"}, pulses, 1);
    endtask

    task automatic run_abort(input int abort_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < abort_at; cyc++) begin
            check($sformatf("abort pre done c%0d", cyc), 32'(done), 32'd0);
            tick();
        end
        reset = 1'b0;
        #1;
        check("abort memReadAddr", 32'(memReadAddr), 32'd0);
        check("abort addOutA", 32'(addOutA), 32'd0);
        check("abort memWriteEn", 32'(memWriteEn), 32'd0);
        check("abort done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort held done", 32'(done), 32'd0);
        end
        shl_pend = 1'b0;
        L_shlDone = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int wr_before, extra_done;
        reset = 1'b0;
        start = 1'b0;
        xAddr = '0;
        aAddr = '0;
        yAddr = '0;
        memIn = '0;
        L_shlIn = '0;
        L_shlDone = 1'b0;
        for (int k = 0; k < 4096; k++) mem[k] = '0;
        repeat (3) tick();
        check("rst memReadAddr", 32'(memReadAddr), 32'd0);
        check("rst memWriteEn", 32'(memWriteEn), 32'd0);
        check("rst memOut", memOut, 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst shlReady", 32'(L_shlReady), 32'd0);
        check("rst addOutA", 32'(addOutA), 32'd0);
        reset = 1'b1;
        tick();
        check("idle done", 32'(done), 32'd0);
        check("idle memWriteEn", 32'(memWriteEn), 32'd0);

        // Identity filter
        for (int k = 0; k < 50; k++) xv[k] = 16'((k - 10) * 100);
        for (int k = 0; k < 11; k++) av[k] = '0;
        av[0] = 16'sd4096;
        load(12'd100, 12'd300, 12'd400);
        run_sub("ident", 1521, 1'b0);
        check_y("ident");
        check("ident y0 const", yw(0), 32'd0);
        check("ident y39 const", yw(39), 32'd3900);

        // First difference, with start held high during the done cycle
        for (int k = 0; k < 50; k++) xv[k] = '0;
        xv[9] = 16'sd50;
        for (int n = 0; n < 40; n++) xv[n + 10] = 16'(1000 + n);
        av[1] = -16'sd4096;
        load(12'd100, 12'd300, 12'd400);
        run_sub("diff", 1521, 1'b1);
        check_y("diff");
        check("diff y0 const", yw(0), 32'd950);
        check("diff y1 const", yw(1), 32'd1);
        wr_before = wr_cnt;
        extra_done = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) extra_done++;
        end
        check("no restart writes", wr_cnt, wr_before);
        check("no restart done", extra_done, 0);

        // Saturation
        for (int k = 0; k < 50; k++) xv[k] = 16'sd32767;
        for (int k = 0; k < 11; k++) av[k] = 16'sd4096;
        load(12'd100, 12'd300, 12'd400);
        run_sub("sat", 1521, 1'b0);
        check_y("sat");
        check("sat y5 const", yw(5), 32'h0000_7FFF);

        // Negative result sign extension
        for (int k = 0; k < 50; k++) xv[k] = 16'($urandom_range(0, 2000)) - 16'sd1000;
        xv[10] = -16'sd300;
        for (int k = 0; k < 11; k++) av[k] = '0;
        av[0] = 16'sd4096;
        load(12'd100, 12'd300, 12'd400);
        run_sub("neg", 1521, 1'b0);
        check_y("neg");
        check("neg y0 const", yw(0), 32'hFFFF_FED4);

        // Shifter stall, history wrapping below address 0
        shl_delay = 4;
        for (int k = 0; k < 50; k++) xv[k] = 16'($urandom());
        for (int k = 0; k < 11; k++) av[k] = 16'($urandom_range(0, 8191)) - 16'sd4096;
        load(12'd3, 12'd1000, 12'd2000);
        run_sub("stall", 1681, 1'b0);
        check_y("stall");
        shl_delay = 0;

        // Full-range random coefficients and samples, x buffer wrapping past 4095
        for (int k = 0; k < 50; k++) xv[k] = 16'($urandom());
        for (int k = 0; k < 11; k++) av[k] = 16'($urandom());
        load(12'd4090, 12'd1000, 12'd2000);
        run_sub("rand", 1521, 1'b0);
        check_y("rand");

        // Reset mid-run, then a clean rerun
        for (int k = 0; k < 50; k++) xv[k] = 16'($urandom_range(0, 4000)) - 16'sd2000;
        for (int k = 0; k < 11; k++) av[k] = 16'($urandom_range(0, 4000)) - 16'sd2000;
        load(12'd100, 12'd300, 12'd400);
        run_abort(500);
        for (int n = 0; n < 13; n++) check($sformatf("abort y[%0d]", n), yw(n), ref_y(n));
        for (int n = 13; n < 40; n++) check($sformatf("abort untouched y[%0d]", n), yw(n), SENT);
        load(12'd100, 12'd300, 12'd400);
        run_sub("rerun", 1521, 1'b0);
        check_y("rerun");

        check("writes outside y", bad_wr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/residu.md
Name: residu

Overview:
- Analysis (inverse) filter A(z) for the G.729 encoder. It computes the LPC residual y[n] = round(sum_{j=0..M} a[j]*x[n-j] << 3) over one L-sample subframe.
- It is the FIR counterpart of the all-pole synthesis filter and uses the same scratch-memory and shared-arithmetic-unit interface.
- Sits in the encoder datapath ahead of pitch/codebook search. All reads, writes and math operations go through the shared memory port and shared operator units.

Parameters:
L, 40, subframe length in samples
M, 10, LPC order; a[0..M] = M+1 coefficients

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin one subframe; sampled only in S_IDLE
xAddr  input  12  address of x[0]; history x[-M..-1] lives at xAddr-M..xAddr-1
aAddr  input  12  address of a[0] (Q12)
yAddr  input  12  address of y[0] output buffer
memIn  input  32  read data, valid the cycle after memReadAddr is driven
memReadAddr  output  12  read address
memWriteAddr  output  12  write address
memWriteEn  output  1  write strobe
memOut  output  32  write data, 16-bit result sign-extended to 32
addOutA, addOutB / addIn  out/out/in  16/16/16  shared 16-bit add
subOutA, subOutB / subIn  out/out/in  16/16/16  shared 16-bit sub
L_addOutA, L_addOutB / L_addIn  out/out/in  32/32/32  shared saturating 32-bit add
L_multOutA, L_multOutB / L_multIn  out/out/in  16/16/32  shared L_mult
L_macOutA, L_macOutB, L_macOutC / L_macIn  out/out/out/in  16/16/32/32  shared L_mac (C + A*B*2, saturating)
L_shlOutVar1, L_shlNumShiftOut, L_shlReady / L_shlIn, L_shlDone  out/out/out/in/in  32/16/1/32/1  shared L_shl handshake
done  output  1  one-cycle pulse at end of subframe

Behaviour:
- Registers: state, i (6b), j (6b), tempX (16b), tempA (16b), tempS (32b).
- All registers clear asynchronously when reset is low. All outputs are combinational from state and default to 0 in every state that does not drive them; every output reads 0 during reset.
- S_IDLE: clear i and j. If start=1, go to S_LOOP; otherwise stay.
- S_LOOP:
  - If i>=L: done=1, go to S_IDLE.
  - Else: memReadAddr=xAddr+i (via add), go to S_RDX.
- S_RDX: tempX<=memIn[15:0]; memReadAddr=aAddr; go to S_MULT.
- S_MULT: tempS<=L_mult(tempX, memIn[15:0]); j<=1; go to S_JCHK.
- S_JCHK:
  - If j>M: go to S_SHL1.
  - Else: memReadAddr=aAddr+j; go to S_RDA.
- S_RDA: tempA<=memIn[15:0]; memReadAddr=xAddr+i-j, computed as add then sub with 12-bit wrap, so reads for i<j hit the history; go to S_MAC.
- S_MAC: tempS<=L_mac(tempS, tempA, memIn[15:0]); j<=j+1; go to S_JCHK.
- S_SHL1: L_shlOutVar1=tempS, L_shlNumShiftOut=3, L_shlReady=1; go to S_SHL2.
- S_SHL2: hold while L_shlDone=0. On L_shlDone=1, tempS<=L_shlIn and go to S_WR.
- S_WR:
  - L_add(tempS, 32'h00008000).
  - memWriteAddr=yAddr+i, memWriteEn=1.
  - memOut = L_addIn[31:16] sign-extended.
  - Go to S_INC.
- S_INC: i<=i+1; go to S_LOOP.
- Arithmetic: saturation is delegated entirely to the shared units. The block performs no internal arithmetic beyond counter and address adds routed through the shared adders.
- Latency per sample is 3M+8 cycles = 38 when L_shlDone returns in the first S_SHL2 cycle. Each extra L_shlDone wait cycle adds one cycle per sample.
- Full subframe: done asserts 1521 cycles after the S_IDLE cycle in which start=1 (L=40, M=10, no shl stall).
- Boundaries:
  - start is ignored outside S_IDLE.
  - start high in the cycle done pulses is not accepted until the next S_IDLE cycle.
  - Reset low mid-subframe aborts immediately: no further writes, done not pulsed.
  - x memory is never written.
  - In-place operation with yAddr=xAddr is not supported.
  - i=0 with j=M reads address xAddr-10.
  - An unknown state returns to S_IDLE with done=1.

Test Plan:
- Identity filter: a[0]=4096, a[1..10]=0, x[-10..39]=n*100 -> y[n]=n*100 for n=0..39; done pulses exactly once at cycle 1521.
- First difference: a[0]=4096, a[1]=-4096, rest 0, x[-1]=50, x[n]=1000+n -> y[0]=950, y[1..39]=1.
- Saturation: x[-10..39]=32767, a[0..10]=4096 -> every y[n]=32767, and memOut upper 16 bits = 0.
- Negative result sign extension: a[0]=4096, x[0]=-300 -> memOut=32'hFFFFFED4 at yAddr.
- Shifter stall: L_shlDone delayed 5 cycles per request -> same y values; done at 1521+40*4=1681.
- Reset mid-run: pull reset low at cycle 500 -> outputs go to 0 immediately, y[13..39] untouched, no done. A fresh start then completes normally.
